// File: rtl/stage4_memory_access.sv
// -----------------------------------------------------------------------------
// stage4_memory_access
//
// LEGv8 pipeline stage 4. Holds the EX/MEM pipeline register, performs the
// data-memory access over a req/ack port, resolves branches and feeds the
// MEM/WB register that drives write-back.
//
// Optional feature macro: LEGV8_MEM_ALIGN_CHECK_EN
//   Defined   : a load/store whose address has non-zero bits [2:0] never issues
//               a memory request; it retires with write-back disabled and
//               raises mem_fault for one cycle.
//   Undefined : no alignment check, mem_fault is constant 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ex_*                 instruction offered by the execute stage
//   stall                upstream must hold; ex_* is not accepted this cycle
//   dmem_req/we/addr/wdata, dmem_ack/rdata
//                        data-memory port; request fields stay stable until ack
//   pc_src, pc_target    taken-branch redirect to fetch
//   wb_valid, wb_regwrite, wb_rd, wb_data
//                        MEM/WB register contents for write-back
//   mem_fault            misaligned access flag (alignment-check build only)
// -----------------------------------------------------------------------------
module stage4_memory_access #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              ex_zero,
    input  logic [XLEN-1:0]   ex_branch_target,
    input  logic              ex_branch,
    input  logic              ex_uncond,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              pc_src,
    output logic [XLEN-1:0]   pc_target,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              mem_fault
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Doubleword accesses only: any set bit in the low three address bits is misaligned.
    function automatic logic is_misaligned(input logic [2:0] addr_lsb);
        return (addr_lsb != 3'b000);
    endfunction

    mem_state_e        state_r;
    mem_state_e        state_next_s;

    // EX/MEM pipeline register
    logic              m_valid_r;
    logic [XLEN-1:0]   m_result_r;
    logic [XLEN-1:0]   m_store_data_r;
    logic              m_zero_r;
    logic [XLEN-1:0]   m_branch_target_r;
    logic              m_branch_r;
    logic              m_uncond_r;
    logic              m_memwrite_r;
    logic              m_memtoreg_r;
    logic              m_regwrite_r;
    logic [REG_AW-1:0] m_rd_r;

    // MEM/WB pipeline register
    logic              wb_valid_r;
    logic              wb_regwrite_r;
    logic [REG_AW-1:0] wb_rd_r;
    logic [XLEN-1:0]   wb_data_r;
    logic              mem_fault_r;

    logic              stall_s;
    logic              advance_s;
    logic              take_branch_s;
    logic              accept_valid_s;
    logic              ex_mem_op_s;
    logic              fault_s;
    logic [XLEN-1:0]   wb_data_s;

`ifdef LEGV8_MEM_ALIGN_CHECK_EN
    logic              m_misaligned_r;

    // Remember that the latched memory op is misaligned; it then bypasses ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_misaligned_r <= 1'b0;
        end else if (advance_s) begin
            m_misaligned_r <= (ex_memread | ex_memwrite) & is_misaligned(ex_result[2:0]);
        end
    end

    assign fault_s = m_valid_r & m_misaligned_r;
`else
    assign fault_s = 1'b0;
`endif

    // Stall, branch resolution and acceptance of the instruction offered by execute.
    always_comb begin
        stall_s        = (state_r == ST_ACCESS) & ~dmem_ack;
        advance_s      = ~stall_s;
        take_branch_s  = m_valid_r & (m_uncond_r | (m_branch_r & m_zero_r));
        // A taken branch in EX/MEM squashes whatever execute offers in the same cycle.
        accept_valid_s = ex_valid & ~take_branch_s;
`ifdef LEGV8_MEM_ALIGN_CHECK_EN
        ex_mem_op_s    = accept_valid_s & (ex_memread | ex_memwrite) & ~is_misaligned(ex_result[2:0]);
`else
        ex_mem_op_s    = accept_valid_s & (ex_memread | ex_memwrite);
`endif
    end

    // Write-back data select; a faulted load has no memory data, so it carries its address.
    always_comb begin
        wb_data_s = m_result_r;
        if (m_memtoreg_r & ~fault_s) begin
            wb_data_s = dmem_rdata;
        end else begin
            wb_data_s = m_result_r;
        end
    end

    // Next-state logic of the memory-access FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ex_mem_op_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Back-to-back memory ops stay in ACCESS across the completing edge.
                if (stall_s | ex_mem_op_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // EX/MEM register: loads on every non-stalled edge, holds during an access.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r         <= 1'b0;
            m_result_r        <= {XLEN{1'b0}};
            m_store_data_r    <= {XLEN{1'b0}};
            m_zero_r          <= 1'b0;
            m_branch_target_r <= {XLEN{1'b0}};
            m_branch_r        <= 1'b0;
            m_uncond_r        <= 1'b0;
            m_memwrite_r      <= 1'b0;
            m_memtoreg_r      <= 1'b0;
            m_regwrite_r      <= 1'b0;
            m_rd_r            <= {REG_AW{1'b0}};
        end else if (advance_s) begin
            m_valid_r         <= accept_valid_s;
            m_result_r        <= ex_result;
            m_store_data_r    <= ex_store_data;
            m_zero_r          <= ex_zero;
            m_branch_target_r <= ex_branch_target;
            m_branch_r        <= ex_branch;
            m_uncond_r        <= ex_uncond;
            m_memwrite_r      <= ex_memwrite;
            m_memtoreg_r      <= ex_memtoreg;
            m_regwrite_r      <= ex_regwrite;
            m_rd_r            <= ex_rd;
        end
    end

    // MEM/WB register: a stalled edge clears the valid bits so nothing retires twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r    <= 1'b0;
            wb_regwrite_r <= 1'b0;
            wb_rd_r       <= {REG_AW{1'b0}};
            wb_data_r     <= {XLEN{1'b0}};
            mem_fault_r   <= 1'b0;
        end else if (advance_s) begin
            wb_valid_r    <= m_valid_r;
            wb_regwrite_r <= m_valid_r & m_regwrite_r & ~fault_s;
            wb_rd_r       <= m_rd_r;
            wb_data_r     <= wb_data_s;
            mem_fault_r   <= fault_s;
        end else begin
            wb_valid_r    <= 1'b0;
            wb_regwrite_r <= 1'b0;
            mem_fault_r   <= 1'b0;
        end
    end

    assign stall       = stall_s;
    assign dmem_req    = (state_r == ST_ACCESS);
    assign dmem_we     = m_memwrite_r;
    assign dmem_addr   = m_result_r;
    assign dmem_wdata  = m_store_data_r;
    assign pc_src      = take_branch_s;
    assign pc_target   = m_branch_target_r;
    assign wb_valid    = wb_valid_r;
    assign wb_regwrite = wb_regwrite_r;
    assign wb_rd       = wb_rd_r;
    assign wb_data     = wb_data_r;
    assign mem_fault   = mem_fault_r;

endmodule

// File: tb/tb_stage4_memory_access.sv
// -----------------------------------------------------------------------------
// tb_stage4_memory_access
//
// Self-checking bench for stage4_memory_access. Every instruction expected to
// retire is pushed onto a scoreboard queue when it is driven; a negedge monitor
// pops and compares each write-back the DUT produces. Directed checks cover
// reset, latency, stalls, branches and the alignment build option.
// -----------------------------------------------------------------------------
module tb_stage4_memory_access;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              rw;
    } wb_exp_t;

    logic              clk;
    logic              rst;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_result;
    logic [XLEN-1:0]   ex_store_data;
    logic              ex_zero;
    logic [XLEN-1:0]   ex_branch_target;
    logic              ex_branch;
    logic              ex_uncond;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_memtoreg;
    logic              ex_regwrite;
    logic [REG_AW-1:0] ex_rd;
    logic              stall;
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_ack;
    logic [XLEN-1:0]   dmem_rdata;
    logic              pc_src;
    logic [XLEN-1:0]   pc_target;
    logic              wb_valid;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              mem_fault;

    int                n_compared   = 0;
    int                n_mismatched = 0;
    wb_exp_t           exp_q[$];
    int                stall_cycles;

    stage4_memory_access #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_store_data    (ex_store_data),
        .ex_zero          (ex_zero),
        .ex_branch_target (ex_branch_target),
        .ex_branch        (ex_branch),
        .ex_uncond        (ex_uncond),
        .ex_memread       (ex_memread),
        .ex_memwrite      (ex_memwrite),
        .ex_memtoreg      (ex_memtoreg),
        .ex_regwrite      (ex_regwrite),
        .ex_rd            (ex_rd),
        .stall            (stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .wb_valid         (wb_valid),
        .wb_regwrite      (wb_regwrite),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .mem_fault        (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data, input logic rw);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        e.rw   = rw;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        ex_valid         = 1'b0;
        ex_result        = 64'h0;
        ex_store_data    = 64'h0;
        ex_zero          = 1'b0;
        ex_branch_target = 64'h0;
        ex_branch        = 1'b0;
        ex_uncond        = 1'b0;
        ex_memread       = 1'b0;
        ex_memwrite      = 1'b0;
        ex_memtoreg      = 1'b0;
        ex_regwrite      = 1'b0;
        ex_rd            = 5'd0;
    endtask

    task automatic drive_alu(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] result);
        drive_idle();
        ex_valid    = 1'b1;
        ex_result   = result;
        ex_regwrite = 1'b1;
        ex_rd       = rd;
    endtask

    task automatic drive_ldur(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] addr);
        drive_idle();
        ex_valid    = 1'b1;
        ex_result   = addr;
        ex_memread  = 1'b1;
        ex_memtoreg = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = rd;
    endtask

    // Scoreboard monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("wb_spurious_retire", 64'd1, 64'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check_value("sb_wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                check_value("sb_wb_data", wb_data, e.data);
                check_value("sb_wb_regwrite", {63'd0, wb_regwrite}, {63'd0, e.rw});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        drive_idle();

        // Reset held for two edges: everything reads zero.
        repeat (2) tick();
        #1;
        check_value("rst_stall", {63'd0, stall}, 64'd0);
        check_value("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check_value("rst_pc_src", {63'd0, pc_src}, 64'd0);
        check_value("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_value("rst_wb_regwrite", {63'd0, wb_regwrite}, 64'd0);
        check_value("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check_value("rst_wb_data", wb_data, 64'd0);
        check_value("rst_mem_fault", {63'd0, mem_fault}, 64'd0);
        rst = 1'b0;

        // ADD: retires two edges after acceptance.
        tick();
        drive_alu(5'd3, 64'h2A);
        push_exp(5'd3, 64'h2A, 1'b1);
        tick();
        drive_idle();
        #1;
        check_value("add_wb_valid_edge1", {63'd0, wb_valid}, 64'd0);
        tick();
        #1;
        check_value("add_wb_valid_edge2", {63'd0, wb_valid}, 64'd1);
        check_value("add_wb_rd", {59'd0, wb_rd}, 64'd3);
        check_value("add_wb_data", wb_data, 64'h2A);
        check_value("add_wb_regwrite", {63'd0, wb_regwrite}, 64'd1);

        // LDUR with three wait cycles; an ADD waits on ex_* during the stall.
        tick();
        drive_ldur(5'd5, 64'h100);
        push_exp(5'd5, 64'hDEADBEEF, 1'b1);
        tick();
        drive_alu(5'd7, 64'h77);
        push_exp(5'd7, 64'h77, 1'b1);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_value("ld_dmem_req", {63'd0, dmem_req}, 64'd1);
            check_value("ld_dmem_addr", dmem_addr, 64'h100);
            check_value("ld_dmem_we", {63'd0, dmem_we}, 64'd0);
            if (stall === 1'b1) stall_cycles++;
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        #1;
        check_value("ld_ack_stall", {63'd0, stall}, 64'd0);
        check_value("ld_ack_addr", dmem_addr, 64'h100);
        check_value("ld_stall_cycles", stall_cycles, 64'd3);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        drive_idle();
        #1;
        check_value("ld_wb_data", wb_data, 64'hDEADBEEF);
        tick();
        #1;
        check_value("ld_next_wb_data", wb_data, 64'h77);

        // STUR with zero-wait ack: single-cycle access, no stall.
        tick();
        drive_idle();
        ex_valid      = 1'b1;
        ex_memwrite   = 1'b1;
        ex_result     = 64'h08;
        ex_store_data = 64'h55;
        push_exp(5'd0, 64'h08, 1'b0);
        tick();
        drive_idle();
        dmem_ack = 1'b1;
        #1;
        check_value("st_dmem_req", {63'd0, dmem_req}, 64'd1);
        check_value("st_dmem_we", {63'd0, dmem_we}, 64'd1);
        check_value("st_dmem_addr", dmem_addr, 64'h08);
        check_value("st_dmem_wdata", dmem_wdata, 64'h55);
        check_value("st_stall", {63'd0, stall}, 64'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        check_value("st_req_drop", {63'd0, dmem_req}, 64'd0);
        check_value("st_we_drop", {63'd0, dmem_we}, 64'd0);
        check_value("st_wb_regwrite", {63'd0, wb_regwrite}, 64'd0);

        // CBZ taken: redirect for one cycle, following instruction squashed.
        tick();
        drive_idle();
        ex_valid         = 1'b1;
        ex_branch        = 1'b1;
        ex_zero          = 1'b1;
        ex_branch_target = 64'h40;
        push_exp(5'd0, 64'h0, 1'b0);
        tick();
        drive_alu(5'd9, 64'h99);
        #1;
        check_value("cbz_pc_src", {63'd0, pc_src}, 64'd1);
        check_value("cbz_pc_target", pc_target, 64'h40);
        tick();
        drive_idle();
        #1;
        check_value("cbz_pc_src_drop", {63'd0, pc_src}, 64'd0);
        tick();
        #1;
        check_value("cbz_squash_wb_valid", {63'd0, wb_valid}, 64'd0);

        // Reset during ACCESS abandons the request.
        tick();
        drive_ldur(5'd6, 64'h200);
        tick();
        drive_idle();
        #1;
        check_value("rstacc_dmem_req", {63'd0, dmem_req}, 64'd1);
        check_value("rstacc_stall", {63'd0, stall}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_value("rstacc_req_drop", {63'd0, dmem_req}, 64'd0);
        check_value("rstacc_stall_drop", {63'd0, stall}, 64'd0);
        check_value("rstacc_wb_valid", {63'd0, wb_valid}, 64'd0);
        tick();
        #1;
        check_value("rstacc_idle", {63'd0, dmem_req}, 64'd0);

        // Misaligned LDUR at 0x103.
        tick();
        drive_ldur(5'd4, 64'h103);
`ifdef LEGV8_MEM_ALIGN_CHECK_EN
        push_exp(5'd4, 64'h103, 1'b0);
        tick();
        drive_idle();
        #1;
        check_value("mis_no_req", {63'd0, dmem_req}, 64'd0);
        check_value("mis_fault_early", {63'd0, mem_fault}, 64'd0);
        tick();
        #1;
        check_value("mis_fault", {63'd0, mem_fault}, 64'd1);
        check_value("mis_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_value("mis_wb_regwrite", {63'd0, wb_regwrite}, 64'd0);
        check_value("mis_no_req_later", {63'd0, dmem_req}, 64'd0);
        tick();
        #1;
        check_value("mis_fault_clear", {63'd0, mem_fault}, 64'd0);
`else
        push_exp(5'd4, 64'h1234, 1'b1);
        tick();
        drive_idle();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1234;
        #1;
        check_value("mis_req", {63'd0, dmem_req}, 64'd1);
        check_value("mis_addr", dmem_addr, 64'h103);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        #1;
        check_value("mis_fault_off", {63'd0, mem_fault}, 64'd0);
        check_value("mis_wb_regwrite", {63'd0, wb_regwrite}, 64'd1);
`endif

        repeat (3) tick();
        check_value("sb_drain", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
